// File: rtl/sig_gen_multi.sv
// Serialises a latched message onto one wire with a configurable bit period,
// length, bit order, repeat count and inter-repeat gap; abort cancels a transfer.
module sig_gen_multi #(
  parameter int MESSAGE_WIDTH = 16,
  parameter int BIT_PERIOD    = 1,
  parameter int GAP_CYCLES    = 0,
  parameter int REPEAT_WIDTH  = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [MESSAGE_WIDTH-1:0]           msg_in,
  input  logic [$clog2(MESSAGE_WIDTH+1)-1:0] len_in,
  input  logic                               lsb_first_in,
  input  logic [REPEAT_WIDTH-1:0]            repeat_in,
  input  logic                               trigger_in,
  input  logic                               abort_in,
  output logic                               data_out,
  output logic                               status_out,
  output logic                               done_out
);

  localparam int LW = $clog2(MESSAGE_WIDTH + 1);
  localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LW-1:0] LMAX = LW'(MESSAGE_WIDTH);
  localparam logic [PW-1:0] PLAST = PW'(BIT_PERIOD - 1);
  localparam logic [GW-1:0] GLAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [REPEAT_WIDTH-1:0] RONE = REPEAT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t                    r_state;
  logic [MESSAGE_WIDTH-1:0]  r_msg;
  logic [LW-1:0]             r_len;
  logic                      r_lsb;
  logic [REPEAT_WIDTH-1:0]   r_rep;
  logic [LW-1:0]             r_idx;
  logic [PW-1:0]             r_per;
  logic [GW-1:0]             r_gap;
  logic                      r_data;
  logic                      r_busy;
  logic                      r_done;

  logic [LW-1:0] w_len;
  logic          w_first;
  logic          w_next;
  logic          w_restart;
  logic          w_last_bit;
  logic          w_per_end;

  // k-th transmitted bit of an L-bit message in the chosen order
  function automatic logic bit_at(
    input logic [MESSAGE_WIDTH-1:0] m,
    input logic [LW-1:0]            l,
    input logic                     lsb,
    input logic [LW-1:0]            k
  );
    logic [LW-1:0]            p;
    logic [MESSAGE_WIDTH-1:0] s;
    p = lsb ? k : l - k - LW'(1);
    s = m >> p;
    return s[0];
  endfunction

  assign w_len = (len_in == '0 || len_in > LMAX) ? LMAX : len_in;
  assign w_first = bit_at(msg_in, w_len, lsb_first_in, '0);
  assign w_next = bit_at(r_msg, r_len, r_lsb, r_idx + LW'(1));
  assign w_restart = bit_at(r_msg, r_len, r_lsb, '0);
  assign w_last_bit = (r_idx == r_len - LW'(1));
  assign w_per_end = (r_per == PLAST);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_msg   <= '0;
      r_len   <= '0;
      r_lsb   <= 1'b0;
      r_rep   <= '0;
      r_idx   <= '0;
      r_per   <= '0;
      r_gap   <= '0;
      r_data  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_data <= 1'b0;
          r_busy <= 1'b0;
          if (trigger_in && !abort_in) begin
            r_state <= S_SEND;
            r_msg   <= msg_in;
            r_len   <= w_len;
            r_lsb   <= lsb_first_in;
            r_rep   <= (repeat_in == '0) ? RONE : repeat_in;
            r_idx   <= '0;
            r_per   <= '0;
            r_data  <= w_first;
            r_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (abort_in) begin
            r_state <= S_IDLE;
            r_data  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (!w_per_end) begin
            r_per <= r_per + PW'(1);
          end else begin
            r_per <= '0;
            if (!w_last_bit) begin
              r_idx  <= r_idx + LW'(1);
              r_data <= w_next;
            end else if (r_rep != RONE) begin
              r_rep <= r_rep - RONE;
              r_idx <= '0;
              if (GAP_CYCLES == 0) begin
                r_data <= w_restart;
              end else begin
                r_state <= S_GAP;
                r_gap   <= '0;
                r_data  <= 1'b0;
              end
            end else begin
              r_state <= S_IDLE;
              r_data  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (abort_in) begin
            r_state <= S_IDLE;
            r_data  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_gap == GLAST) begin
            r_state <= S_SEND;
            r_per   <= '0;
            r_data  <= w_restart;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_data  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign status_out = r_busy;
  assign done_out   = r_done;

endmodule

// File: tb/tb_sig_gen_multi.sv
// Directed bench for sig_gen_multi: three instances cover the default timing,
// stretched bits and gapped repeats.
module tb_sig_gen_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] msg;
  logic [4:0]  len;
  logic        lsb;
  logic [3:0]  rep;
  logic [2:0]  trig;
  logic        abort;
  logic [2:0]  dat;
  logic [2:0]  sts;
  logic [2:0]  dn;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  sig_gen_multi #(
    .MESSAGE_WIDTH(16), .BIT_PERIOD(1),
    .GAP_CYCLES(0), .REPEAT_WIDTH(4)
  ) u_dflt (
    .clk_in(clk), .rst_in(rst_n), .msg_in(msg), .len_in(len),
    .lsb_first_in(lsb), .repeat_in(rep), .trigger_in(trig[0]),
    .abort_in(abort), .data_out(dat[0]), .status_out(sts[0]),
    .done_out(dn[0])
  );

  sig_gen_multi #(
    .MESSAGE_WIDTH(16), .BIT_PERIOD(3),
    .GAP_CYCLES(0), .REPEAT_WIDTH(4)
  ) u_slow (
    .clk_in(clk), .rst_in(rst_n), .msg_in(msg), .len_in(len),
    .lsb_first_in(lsb), .repeat_in(rep), .trigger_in(trig[1]),
    .abort_in(abort), .data_out(dat[1]), .status_out(sts[1]),
    .done_out(dn[1])
  );

  sig_gen_multi #(
    .MESSAGE_WIDTH(16), .BIT_PERIOD(1),
    .GAP_CYCLES(2), .REPEAT_WIDTH(4)
  ) u_gap (
    .clk_in(clk), .rst_in(rst_n), .msg_in(msg), .len_in(len),
    .lsb_first_in(lsb), .repeat_in(rep), .trigger_in(trig[2]),
    .abort_in(abort), .data_out(dat[2]), .status_out(sts[2]),
    .done_out(dn[2])
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle_all(input string tg);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s data%0d", tg, i), dat[i], 1'b0);
      chk($sformatf("%s status%0d", tg, i), sts[i], 1'b0);
      chk($sformatf("%s done%0d", tg, i), dn[i], 1'b0);
    end
  endtask

  task automatic start(input int d, input logic [15:0] m,
                       input logic [4:0] l, input logic o,
                       input logic [3:0] r);
    msg = m;
    len = l;
    lsb = o;
    rep = r;
    trig[d] = 1'b1;
    step;
    trig[d] = 1'b0;
  endtask

  // Checks n busy cycles against exp (first cycle = exp[n-1]); rt pulses a
  // retrigger at that cycle, ab asserts abort at that cycle (-1 = never).
  task automatic send(input int d, input logic [63:0] exp, input int n,
                      input int rt, input int ab, input string tg);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s data[%0d]", tg, k), dat[d], exp[n-1-k]);
      chk($sformatf("%s status[%0d]", tg, k), sts[d], 1'b1);
      chk($sformatf("%s done[%0d]", tg, k), dn[d], 1'b0);
      trig[d] = (k == rt);
      abort = (k == ab);
      msg = ~msg;
      step;
      if (k == ab) begin
        abort = 1'b0;
        chk($sformatf("%s abort data", tg), dat[d], 1'b0);
        chk($sformatf("%s abort status", tg), sts[d], 1'b0);
        chk($sformatf("%s abort done", tg), dn[d], 1'b0);
        return;
      end
    end
    trig[d] = 1'b0;
    chk($sformatf("%s end status", tg), sts[d], 1'b0);
    chk($sformatf("%s end data", tg), dat[d], 1'b0);
    chk($sformatf("%s end done", tg), dn[d], 1'b1);
    step;
    chk($sformatf("%s post done", tg), dn[d], 1'b0);
    chk($sformatf("%s post status", tg), sts[d], 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    msg = 16'hBEEF;
    len = '0;
    lsb = 1'b0;
    rep = 4'd1;
    trig = 3'b111;
    abort = 1'b0;
    #1;
    idle_all("rst t0");
    step;
    idle_all("rst c1");
    step;
    idle_all("rst c2");
    trig = 3'b000;
    rst_n = 1'b1;
    step;
    idle_all("rel c1");
    step;
    idle_all("rel c2");

    start(0, 16'hBEEF, 5'd0, 1'b0, 4'd1);
    send(0, 64'hBEEF, 16, 5, -1, "beef");
    step;
    idle_all("beef after");

    start(1, 16'hFFB5, 5'd8, 1'b1, 4'd1);
    send(1, 64'hE38FC7, 24, -1, -1, "lsb3");
    step;

    start(2, 16'hFFF9, 5'd4, 1'b0, 4'd3);
    send(2, 64'h9249, 16, -1, -1, "gap");
    step;

    start(0, 16'hA5A5, 5'd16, 1'b0, 4'd1);
    send(0, 64'hA5A5, 16, -1, 5, "abort");
    start(0, 16'hBEEF, 5'd20, 1'b0, 4'd0);
    send(0, 64'hBEEF, 16, -1, -1, "restart");
    step;

    start(2, 16'h0009, 5'd4, 1'b0, 4'd2);
    step;
    step;
    step;
    step;
    chk("ingap status", sts[2], 1'b1);
    chk("ingap data", dat[2], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst status", sts[2], 1'b0);
    chk("arst data", dat[2], 1'b0);
    chk("arst done", dn[2], 1'b0);
    #3;
    rst_n = 1'b1;
    step;
    idle_all("arst rel");
    step;
    idle_all("arst rel2");

    msg = 16'hFFFF;
    len = '0;
    abort = 1'b1;
    trig = 3'b111;
    step;
    abort = 1'b0;
    trig = 3'b000;
    idle_all("trig+abort");
    step;
    idle_all("trig+abort2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sig_gen_multi.md
# sig_gen_multi

Parametrised successor to the single-shot message signal generator. On a trigger it latches a message of up to MESSAGE_WIDTH bits and serialises it onto a single output line. Bit period, transmitted length, bit order, repeat count and inter-repeat gap are all configurable, and an abort input cancels a transfer in flight. It sits between control logic (button or FSM trigger) and a pin or downstream single-wire consumer.

## Interface
- MESSAGE_WIDTH, 16, maximum message length in bits (≥2).
- BIT_PERIOD, 1, clock cycles each bit is held on data_out (≥1).
- GAP_CYCLES, 0, idle cycles (data_out=0, still busy) between repeats; 0 means back-to-back.
- REPEAT_WIDTH, 4, width of repeat_in.
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- msg_in  input  MESSAGE_WIDTH  message; latched at trigger.
- len_in  input  $clog2(MESSAGE_WIDTH+1)  bits to send; latched at trigger.
- lsb_first_in  input  1  bit order: 0 = MSB-first, 1 = LSB-first; latched at trigger.
- repeat_in  input  REPEAT_WIDTH  number of transmissions; latched at trigger.
- trigger_in  input  1  start request; sampled only in IDLE.
- abort_in  input  1  cancel the current transfer.
- data_out  output  1  serial bit stream.
- status_out  output  1  busy flag: high from the first bit through the last bit of the last repeat, including gaps.
- done_out  output  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, SEND, GAP.
- **IDLE**
  - data_out=0, status_out=0.
  - trigger_in=1 and abort_in=0 latches msg, len, lsb_first and repeat, then goes to SEND.
- **Length rules**
  - len_in=0 or len_in>MESSAGE_WIDTH sends MESSAGE_WIDTH bits.
  - Bits sent are msg[L-1:0] only; upper bits are ignored.
- **Repeat rules**
  - repeat_in=0 is treated as 1.
- **Bit order**
  - MSB-first sends msg[L-1], msg[L-2], …, msg[0].
  - LSB-first sends msg[0], …, msg[L-1].
- **SEND**
  - A period counter holds each bit for BIT_PERIOD cycles.
  - A bit index advances once per period.
  - After bit L-1 of a repeat: if repeats remain, go to GAP (or straight to the next repeat's first bit if GAP_CYCLES=0). Otherwise go to IDLE and pulse done_out.
- **GAP**
  - data_out=0, status_out=1 for GAP_CYCLES cycles, then SEND restarting at the first bit.
- **Trigger and input changes**
  - trigger_in while SEND or GAP is ignored; it is not queued.
  - Changes to msg_in and the other config inputs mid-transfer have no effect.
- **Abort**
  - abort_in=1 in SEND or GAP returns to IDLE at the next edge.
  - data_out=0 and status_out=0 from that edge; no done_out.
  - abort_in with trigger_in in IDLE: abort wins, no start.
- **Reset**
  - rst_in=0 at any time, including mid-transfer, immediately forces IDLE.
  - data_out=0, status_out=0, done_out=0, and all counters cleared.
  - Operation resumes on the first edge after rst_in rises.

## Timing
- Reset values: data_out=0, status_out=0, done_out=0.
- **Start latency:** trigger sampled at edge N gives first bit on data_out and status_out=1 from edge N (visible cycle N+1).
- **Transfer length:** one repeat occupies L×BIT_PERIOD cycles. The total busy time is R×L×BIT_PERIOD + (R-1)×GAP_CYCLES cycles.
- **Completion:** at the edge ending the final bit period, status_out→0, data_out→0 and done_out→1 for exactly one cycle.
- **Retrigger:** a trigger in the same cycle done_out is high is accepted; the state is IDLE. Back-to-back messages therefore have a 1-cycle gap.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Reset behaviour:** hold rst_in=0 for 2 cycles with trigger_in=1 -> data_out=0, status_out=0, done_out=0 throughout, and no transfer after release.
- **Default single transfer:** MESSAGE_WIDTH=16, msg=16'hBEEF, len=0, MSB-first, BIT_PERIOD=1, repeat=1, 1-cycle trigger -> data_out reads 1011111011101111 over 16 cycles. status_out is high for exactly 16 cycles, done_out pulses once, and a second trigger mid-transfer is ignored.
- **Short LSB-first with stretched bits:** msg=16'h00B5, len=8, LSB-first, BIT_PERIOD=3 -> bits 1,0,1,0,1,1,0,1, each held 3 cycles. status_out is high for 24 cycles.
- **Repeats with gap:** msg=4'b1001, len=4, repeat=3, GAP_CYCLES=2 -> 1001,00,1001,00,1001 on data_out. status_out is high for 16 cycles, and done_out is a single pulse after the third repeat.
- **Abort mid-transfer:** abort_in=1 on bit 5 of a 16-bit send -> next cycle data_out=0, status_out=0, no done_out. A new trigger 1 cycle later starts cleanly from bit 0.
- **Async reset mid-transfer and simultaneous requests:** rst_in=0 during GAP, asynchronous, between clock edges -> outputs drop immediately. Trigger and abort asserted together in IDLE -> no start.
